// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request/ready handshake, IF/ID register.
// Optional STALL_COUNT_EN adds a saturating stall-cycle counter port.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCwrite,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_buf_r, inst_buf_s;
    logic [31:0] saved_target_r, saved_target_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] pc4_r, pc4_s;
    logic        valid_r, valid_s;
    logic        stall_s;
    logic [31:0] pc_plus4_s;

    assign stall_s    = !PCwrite || !if_id_write;
    assign pc_plus4_s = pc_r + 32'd4;

    // Request is suppressed combinationally while reset is held and in HOLD
    assign imem_req    = rst && (state_r != HOLD);
    assign imem_addr   = pc_r;
    assign if_id_inst  = inst_r;
    assign if_id_pc4   = pc4_r;
    assign if_id_valid = valid_r;

    // Next-state, PC and IF/ID update; branch outranks stall in every state
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        inst_buf_s     = inst_buf_r;
        saved_target_s = saved_target_r;
        inst_s         = inst_r;
        pc4_s          = pc4_r;
        valid_s        = valid_r;
        case (state_r)
            FETCH: begin
                if (branch_taken) begin
                    valid_s = 1'b0;
                    if (imem_ready) begin
                        pc_s = branch_target;
                    end else begin
                        saved_target_s = branch_target;
                        state_s        = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (stall_s) begin
                        inst_buf_s = imem_rdata;
                        state_s    = HOLD;
                    end else begin
                        inst_s  = imem_rdata;
                        pc4_s   = pc_plus4_s;
                        valid_s = 1'b1;
                        pc_s    = pc_plus4_s;
                    end
                end else if (!stall_s) begin
                    valid_s = 1'b0;
                end else begin
                    valid_s = valid_r;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    valid_s = 1'b0;
                    pc_s    = branch_target;
                    state_s = FETCH;
                end else if (!stall_s) begin
                    inst_s  = inst_buf_r;
                    pc4_s   = pc_plus4_s;
                    valid_s = 1'b1;
                    pc_s    = pc_plus4_s;
                    state_s = FETCH;
                end else begin
                    state_s = HOLD;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    valid_s        = 1'b0;
                    saved_target_s = branch_target;
                    if (imem_ready) begin
                        pc_s    = branch_target;
                        state_s = FETCH;
                    end else begin
                        state_s = DRAIN;
                    end
                end else begin
                    valid_s = stall_s ? valid_r : 1'b0;
                    if (imem_ready) begin
                        pc_s    = saved_target_r;
                        state_s = FETCH;
                    end else begin
                        state_s = DRAIN;
                    end
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = FETCH;
            end
        endcase
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= FETCH;
            pc_r           <= RESET_PC;
            inst_buf_r     <= 32'd0;
            saved_target_r <= 32'd0;
            inst_r         <= 32'd0;
            pc4_r          <= 32'd0;
            valid_r        <= 1'b0;
        end else begin
            state_r        <= state_s;
            pc_r           <= pc_s;
            inst_buf_r     <= inst_buf_s;
            saved_target_r <= saved_target_s;
            inst_r         <= inst_s;
            pc4_r          <= pc4_s;
            valid_r        <= valid_s;
        end
    end

`ifdef STALL_COUNT_EN
    logic [15:0] stall_count_r;
    assign stall_count = stall_count_r;

    // Saturating count of non-branch stall edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= 16'd0;
        end else if (stall_s && !branch_taken && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID contents are queued per step
// and popped after the clock edge; imem returns address-tagged words.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        PCwrite;
    logic        if_id_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;
    exp_t sb[$];

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCwrite      (PCwrite),
        .if_id_write  (if_id_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .if_id_inst   (if_id_inst),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid)
`ifdef STALL_COUNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    function automatic logic [31:0] tagw(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    assign imem_rdata = imem_ready ? tagw(imem_addr) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check the combinational request, queue IF/ID expectation, clock, compare
    task automatic step(input string tag, input logic pw, input logic iw, input logic bt,
                        input logic [31:0] tgt, input logic rdy,
                        input logic [31:0] e_addr, input logic e_req,
                        input logic e_v, input logic [31:0] e_pc4, input logic [31:0] e_inst);
        exp_t e;
        PCwrite       = pw;
        if_id_write   = iw;
        branch_taken  = bt;
        branch_target = tgt;
        imem_ready    = rdy;
        #1;
        chk({tag, ".addr"}, imem_addr, e_addr);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, e_req});
        e.valid = e_v;
        e.pc4   = e_pc4;
        e.inst  = e_inst;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        chk({tag, ".pc4"}, if_id_pc4, e.pc4);
        chk({tag, ".inst"}, if_id_inst, e.inst);
    endtask

    initial begin
        rst           = 1'b0;
        PCwrite       = 1'b1;
        if_id_write   = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        imem_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, 32'd0);
        chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst.pc4", if_id_pc4, 32'd0);
        chk("rst.inst", if_id_inst, 32'd0);
        rst = 1'b1;

        // Zero-wait stream
        step("zw0", 1, 1, 0, 0, 1, 32'h00, 1, 1, 32'h04, tagw(32'h00));
        step("zw1", 1, 1, 0, 0, 1, 32'h04, 1, 1, 32'h08, tagw(32'h04));
        step("zw2", 1, 1, 0, 0, 1, 32'h08, 1, 1, 32'h0C, tagw(32'h08));
        step("zw3", 1, 1, 0, 0, 1, 32'h0C, 1, 1, 32'h10, tagw(32'h0C));
        // Stall catches in-flight fetch at 0x10
        step("st0", 0, 1, 0, 0, 1, 32'h10, 1, 1, 32'h10, tagw(32'h0C));
        step("st1", 0, 1, 0, 0, 1, 32'h10, 0, 1, 32'h10, tagw(32'h0C));
        step("st2", 1, 0, 0, 0, 1, 32'h10, 0, 1, 32'h10, tagw(32'h0C));
        step("st3", 1, 1, 0, 0, 0, 32'h10, 0, 1, 32'h14, tagw(32'h10));
        step("st4", 1, 1, 0, 0, 0, 32'h14, 1, 0, 32'h14, tagw(32'h10));
        step("st5", 1, 1, 0, 0, 1, 32'h14, 1, 1, 32'h18, tagw(32'h14));
        step("st6", 1, 1, 0, 0, 1, 32'h18, 1, 1, 32'h1C, tagw(32'h18));
        step("st7", 1, 1, 0, 0, 1, 32'h1C, 1, 1, 32'h20, tagw(32'h1C));
        // Branch while waiting: drain 0x20 then redirect to 0x100
        step("bw0", 1, 1, 1, 32'h100, 0, 32'h20, 1, 0, 32'h20, tagw(32'h1C));
        step("bw1", 1, 1, 0, 0, 0, 32'h20, 1, 0, 32'h20, tagw(32'h1C));
        step("bw2", 1, 1, 0, 0, 1, 32'h20, 1, 0, 32'h20, tagw(32'h1C));
        step("bw3", 1, 1, 0, 0, 1, 32'h100, 1, 1, 32'h104, tagw(32'h100));
        // Branch and stall in the same cycle
        step("bs0", 0, 1, 1, 32'h200, 1, 32'h104, 1, 0, 32'h104, tagw(32'h100));
        step("bs1", 1, 1, 0, 0, 1, 32'h200, 1, 1, 32'h204, tagw(32'h200));
        // Branch out of HOLD
        step("bh0", 1, 0, 0, 0, 1, 32'h204, 1, 1, 32'h204, tagw(32'h200));
        step("bh1", 1, 0, 1, 32'h300, 0, 32'h204, 0, 0, 32'h204, tagw(32'h200));
        step("bh2", 1, 1, 0, 0, 1, 32'h300, 1, 1, 32'h304, tagw(32'h300));
        // Wrap past the top of the address space
        step("wr0", 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h304, 1, 0, 32'h304, tagw(32'h300));
        step("wr1", 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0, tagw(32'hFFFF_FFFC));
        step("wr2", 1, 1, 0, 0, 1, 32'h0, 1, 1, 32'h4, tagw(32'h0));

`ifdef STALL_COUNT_EN
        chk("sc.acc", {16'd0, stall_count}, 32'd4);
`endif
        // Reset in the middle of an outstanding request
        imem_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("mrst.req", {31'd0, imem_req}, 32'd0);
        chk("mrst.addr", imem_addr, 32'd0);
        chk("mrst.valid", {31'd0, if_id_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

`ifdef STALL_COUNT_EN
        chk("sc.rst", {16'd0, stall_count}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step("sc5", 0, 1, 0, 0, 0, 32'h0, 1, 0, 32'h0, 32'h0);
        end
        chk("sc.five", {16'd0, stall_count}, 32'd5);
        PCwrite = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sc.sat", {16'd0, stall_count}, 32'h0000_FFFF);
        PCwrite = 1'b1;
`endif
        step("post", 1, 1, 0, 0, 1, 32'h0, 1, 1, 32'h4, tagw(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request/ready handshake, and holds the IF/ID pipeline register. It sits directly upstream of the hazard unit. It consumes the unit's `PCwrite`/`if_id_write` stall pair, and it consumes branch redirects from ID. A single-entry holding buffer lets a stall arrive while a memory fetch is in flight without losing or replaying the instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `PCwrite` in 1: from hazard unit; 0 = stall.
- `if_id_write` in 1: from hazard unit; 0 = stall.
- `branch_taken` in 1: redirect request from ID.
- `branch_target` in 32: redirect address, valid when `branch_taken`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equal to the current PC.
- `imem_rdata` in 32: instruction, valid when `imem_ready`=1.
- `imem_ready` in 1: fetch complete; may be asserted in the same cycle as `imem_req` (zero-wait memory).
- `if_id_inst` out 32: IF/ID instruction.
- `if_id_pc4` out 32: IF/ID PC+4.
- `if_id_valid` out 1: IF/ID holds a real instruction; 0 = bubble.
- `stall_count` out 16: present only with `STALL_COUNT_EN`.

## Operation
- The block treats `stall = !PCwrite || !if_id_write` as one combined stall.
- **Handshake:**
  - `imem_addr` must be held stable while `imem_req`=1 until `imem_ready`=1.
  - The PC is never changed while a request is outstanding.
  - `imem_ready` is ignored whenever `imem_req`=0.
- **FSM states:**
  - **FETCH**
    - Drives `imem_req`=1.
    - On `imem_ready` with no stall: write the instruction to IF/ID, set valid=1, set pc4=PC+4, PC <= PC+4, stay in FETCH.
    - On `imem_ready` with stall: capture `imem_rdata` into `inst_buf`, go to HOLD. PC does not change.
    - No `imem_ready` and no stall: write a bubble (valid=0) into IF/ID.
    - No `imem_ready` and stall: IF/ID holds.
  - **HOLD**
    - Drives `imem_req`=0.
    - While stall=1: IF/ID holds.
    - When stall=0: write `inst_buf` to IF/ID with valid=1, PC <= PC+4, go to FETCH.
  - **DRAIN**
    - Drives `imem_req`=1 on the old address.
    - On `imem_ready`: discard the data, PC <= `saved_target`, go to FETCH.
    - IF/ID valid is forced to 0 in this state unless stall=1, in which case IF/ID holds.
- **Branch (`branch_taken`=1):** highest priority; overrides stall. IF/ID valid <= 0 in the same edge.
  - FETCH with `imem_ready`=1: discard the data, PC <= `branch_target`, stay in FETCH.
  - FETCH with `imem_ready`=0: `saved_target` <= `branch_target`, go to DRAIN.
  - HOLD: drop `inst_buf`, PC <= `branch_target`, go to FETCH.
  - DRAIN: overwrite `saved_target`. If `imem_ready`=1 in the same cycle, PC <= the new target and go to FETCH.
- **Arithmetic:** PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. The block does not check PC alignment.

## Timing
- **Reset values:**
  - Internal: PC = `RESET_PC`, state = FETCH, `inst_buf` = 0, `saved_target` = 0.
  - Outputs: `if_id_inst` = 0, `if_id_pc4` = 0, `if_id_valid` = 0, `stall_count` = 0.
  - `imem_req` = 0 while `rst` is low, gated combinationally. It rises in the first cycle after release.
- **Fetch latency:** IF/ID updates on the edge where `imem_ready`=1 in FETCH. Zero-wait memory gives throughput of 1 instruction per cycle.
- **Stall release from HOLD:** the buffered instruction enters IF/ID on the first edge with stall=0, and FETCH of PC+4 begins in the following cycle. This costs one bubble after a stall that caught an in-flight fetch.
- **Branch with zero-wait memory:** the fetch from the target issues in the cycle after `branch_taken`, giving exactly one flushed slot.
- **Reset mid-operation:** any outstanding request is abandoned. Memory must tolerate `imem_req` dropping without `imem_ready`.

## Configuration
- `STALL_COUNT_EN` defined:
  - Adds the `stall_count` port.
  - `stall_count` increments on every edge where stall=1 and `branch_taken`=0.
  - It saturates at 16'hFFFF and clears only on reset.
- `STALL_COUNT_EN` undefined:
  - The port and counter logic are absent; the rest of the behaviour is identical.

## Test plan
- **Reset then zero-wait fetch:** release `rst`, hold `imem_ready`=1, imem returns addr-tagged words. Required: IF/ID pc4 = 4, 8, 12 on successive edges, `if_id_valid`=1 from the first edge, `imem_addr` = 0, 4, 8.
- **Stall during in-flight fetch:** `imem_ready` and stall both 1 at PC=0x10 for 3 cycles. Required: state HOLD, `imem_req`=0, IF/ID unchanged. On release, IF/ID inst = word@0x10 with pc4=0x14, then the next fetch is 0x14.
- **Branch while waiting:** `imem_ready`=0 at PC=0x20, `branch_taken` with target 0x100, then `imem_ready` 2 cycles later. Required: `imem_addr` stays 0x20 until ready, the data is discarded, the next `imem_addr` = 0x100, and `if_id_valid`=0 throughout.
- **Branch plus stall in the same cycle:** required: flush wins, `if_id_valid`=0, PC = target.
- **Wrap:** `branch_target` = 32'hFFFF_FFFC with zero-wait memory. Required: the next `imem_addr` = 0 and `if_id_pc4` = 0.
- **`STALL_COUNT_EN`:** 5 stall cycles give `stall_count`=5. Forcing 70000 stall cycles holds `stall_count` at 16'hFFFF.
